ibex_fetch_stream_gen: RTL and testbench

Producer side of the instruction-fetch handshake (fetch_valid/ready, rdata, addr, err, err_plus2). It issues word requests on an OBI-style instruction bus, buffers the returned words in a small FIFO and presents them in order to the fetch consumer. It handles redirects, discards stale responses and stops on bus errors. It drives the same signal set the fetch monitor samples, so it serves as a DV fetch source and as a lightweight prefetcher.

---
 rtl/ibex_fetch_stream_gen.sv | 213 +++++++++++++++++++++
 tb/tb_ibex_fetch_stream_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_stream_gen.sv
// ibex_fetch_stream_gen
//
// Instruction-fetch stream producer. Issues word requests on an OBI-style
// instruction bus, buffers returned words in a small FIFO and presents them
// in order on the fetch handshake. Redirects flush the buffer and retarget
// the stream; responses that belong to the old stream are counted and
// dropped. A bus error ends the stream until the next redirect.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i                 fetch enable (gates issuing new requests)
//   branch_i, addr_i      one-cycle redirect strobe and target
//   fetch_ready_i         consumer accepts the head word
//   fetch_valid_o         head word available
//   fetch_rdata_o         head word data (0 for errored entries)
//   fetch_addr_o          word address of the head word
//   fetch_err_o           head word carried a bus error
//   fetch_err_plus2_o     always 0 (word-aligned stream)
//   instr_req_o/addr_o    bus request and word address
//   instr_gnt_i           bus grant
//   instr_rvalid_i/rdata_i/err_i  bus response
//   busy_o                request active or any request outstanding

module ibex_fetch_stream_gen #(
  parameter int DEPTH           = 3,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  output logic        fetch_err_plus2_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  // Counter width leaves headroom so outstanding + buffered never wraps.
  localparam int CW = $clog2(2 * DEPTH + 2);
  localparam int IW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  // State
  logic [31:0]   issue_ptr_reg,   issue_ptr_next;
  logic [31:0]   read_ptr_reg,    read_ptr_next;
  logic [31:0]   pend_target_reg, pend_target_next;
  logic          pend_reg,        pend_next;
  logic          hold_reg,        hold_next;
  logic          stop_reg,        stop_next;
  logic [CW-1:0] out_cnt_reg,     out_cnt_next;
  logic [CW-1:0] disc_cnt_reg,    disc_cnt_next;
  logic [CW-1:0] fifo_cnt_reg,    fifo_cnt_next;
  logic [IW-1:0] wr_idx_reg,      wr_idx_next;
  logic [IW-1:0] rd_idx_reg,      rd_idx_next;

  // FIFO storage (data is not reset; outputs are gated by valid)
  logic [31:0] mem_data [DEPTH];
  logic        mem_err  [DEPTH];

  logic [31:0] target;
  logic        can_issue;
  logic        fire;
  logic        held_after;
  logic        resp_ok;
  logic        push;
  logic        pop;

  assign target = addr_i & 32'hFFFF_FFFC;

  // A new request may start only with room for its response; once raised it
  // is kept up by hold_reg until granted, whatever the other inputs do.
  assign can_issue = ~rst_i & req_i & ~stop_reg & (out_cnt_reg < MAX_C)
                     & ((out_cnt_reg + fifo_cnt_reg) < DEPTH_C);
  assign instr_req_o  = hold_reg | can_issue;
  assign instr_addr_o = issue_ptr_reg;

  assign fire       = instr_req_o & instr_gnt_i;
  assign held_after = instr_req_o & ~instr_gnt_i;

  // Responses with nothing outstanding (e.g. strays after reset) are ignored.
  assign resp_ok = instr_rvalid_i & (out_cnt_reg != '0);
  assign push    = resp_ok & ~branch_i & (disc_cnt_reg == '0) & ~stop_reg;
  assign pop     = fetch_valid_o & fetch_ready_i & ~branch_i;

  assign fetch_valid_o     = (fifo_cnt_reg != '0);
  assign fetch_rdata_o     = fetch_valid_o ? mem_data[rd_idx_reg] : 32'h0;
  assign fetch_err_o       = fetch_valid_o & mem_err[rd_idx_reg];
  assign fetch_addr_o      = read_ptr_reg;
  assign fetch_err_plus2_o = 1'b0;
  assign busy_o            = instr_req_o | (out_cnt_reg != '0);

  always_comb begin
    out_cnt_next = out_cnt_reg;
    if (fire && !resp_ok) begin
      out_cnt_next = out_cnt_reg + ONE_C;
    end else if (!fire && resp_ok) begin
      out_cnt_next = out_cnt_reg - ONE_C;
    end
  end

  always_comb begin
    issue_ptr_next   = issue_ptr_reg;
    pend_next        = pend_reg;
    pend_target_next = pend_target_reg;
    hold_next        = held_after;
    disc_cnt_next    = disc_cnt_reg;
    stop_next        = stop_reg;
    read_ptr_next    = read_ptr_reg;
    fifo_cnt_next    = fifo_cnt_reg;
    wr_idx_next      = wr_idx_reg;
    rd_idx_next      = rd_idx_reg;

    if (branch_i) begin
      // Everything in flight after this edge belongs to the old stream,
      // including a still-ungranted request that must complete at its
      // old address before the target can be issued.
      disc_cnt_next = out_cnt_next + (held_after ? ONE_C : '0);
      if (held_after) begin
        pend_next        = 1'b1;
        pend_target_next = target;
      end else begin
        pend_next      = 1'b0;
        issue_ptr_next = target;
      end
      stop_next     = 1'b0;
      read_ptr_next = target;
      fifo_cnt_next = '0;
      wr_idx_next   = '0;
      rd_idx_next   = '0;
    end else begin
      if (fire) begin
        if (pend_reg) begin
          issue_ptr_next = pend_target_reg;
          pend_next      = 1'b0;
        end else begin
          issue_ptr_next = issue_ptr_reg + 32'd4;
        end
      end

      if (resp_ok && disc_cnt_reg != '0) begin
        disc_cnt_next = disc_cnt_reg - ONE_C;
      end

      if (push && instr_err_i) begin
        stop_next = 1'b1;
      end

      if (push) begin
        wr_idx_next = (wr_idx_reg == LAST_IDX) ? '0 : wr_idx_reg + IW'(1);
      end
      if (pop) begin
        rd_idx_next   = (rd_idx_reg == LAST_IDX) ? '0 : rd_idx_reg + IW'(1);
        read_ptr_next = read_ptr_reg + 32'd4;
      end
      if (push && !pop) begin
        fifo_cnt_next = fifo_cnt_reg + ONE_C;
      end else if (pop && !push) begin
        fifo_cnt_next = fifo_cnt_reg - ONE_C;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_ptr_reg   <= '0;
      read_ptr_reg    <= '0;
      pend_target_reg <= '0;
      pend_reg        <= 1'b0;
      hold_reg        <= 1'b0;
      stop_reg        <= 1'b0;
      out_cnt_reg     <= '0;
      disc_cnt_reg    <= '0;
      fifo_cnt_reg    <= '0;
      wr_idx_reg      <= '0;
      rd_idx_reg      <= '0;
    end else begin
      issue_ptr_reg   <= issue_ptr_next;
      read_ptr_reg    <= read_ptr_next;
      pend_target_reg <= pend_target_next;
      pend_reg        <= pend_next;
      hold_reg        <= hold_next;
      stop_reg        <= stop_next;
      out_cnt_reg     <= out_cnt_next;
      disc_cnt_reg    <= disc_cnt_next;
      fifo_cnt_reg    <= fifo_cnt_next;
      wr_idx_reg      <= wr_idx_next;
      rd_idx_reg      <= rd_idx_next;
    end
  end

  // Errored words are buffered with zero data so no bus garbage leaks out.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_idx_reg] <= instr_err_i ? 32'h0 : instr_rdata_i;
      mem_err[wr_idx_reg]  <= instr_err_i;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_stream_gen.sv
// Randomized scoreboard bench for ibex_fetch_stream_gen. The expected fetch
// stream is derived from the address-level rules: after a redirect to T the
// consumer sees T, T+4, ... with memory contents, ending at the first
// errored word. A bus model grants and answers requests at random.

module tb_ibex_fetch_stream_gen;

  localparam int DEPTH   = 3;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        fetch_ready_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_err_o;
  logic        fetch_err_plus2_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        busy_o;

  always #5 clk = ~clk;

  ibex_fetch_stream_gen #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .branch_i         (branch_i),
    .addr_i           (addr_i),
    .fetch_ready_i    (fetch_ready_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_rdata_o    (fetch_rdata_o),
    .fetch_addr_o     (fetch_addr_o),
    .fetch_err_o      (fetch_err_o),
    .fetch_err_plus2_o(fetch_err_plus2_o),
    .instr_req_o      (instr_req_o),
    .instr_addr_o     (instr_addr_o),
    .instr_gnt_i      (instr_gnt_i),
    .instr_rvalid_i   (instr_rvalid_i),
    .instr_rdata_i    (instr_rdata_i),
    .instr_err_i      (instr_err_i),
    .busy_o           (busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] bus_q[$];
  logic [31:0] gen_addr;
  bit          gen_stop;
  bit          stray;
  bit          err_popped;
  int          post_err_grants;
  int          pops;
  int          vectors;
  int          errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h2545_F491;
    return (h[31:27] == 5'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Keep a short window of the infinite expected stream queued.
  function automatic void topup();
    while (!gen_stop && exp_q.size() < 8) begin
      exp_t e;
      e.addr = gen_addr;
      e.err  = mem_err(gen_addr);
      e.data = e.err ? 32'h0 : mem_word(gen_addr);
      exp_q.push_back(e);
      if (e.err) gen_stop = 1'b1;
      gen_addr = gen_addr + 32'd4;
    end
  endfunction

  task automatic do_branch(input logic [31:0] a);
    branch_i        = 1'b1;
    addr_i          = a;
    exp_q.delete();
    gen_addr        = a & 32'hFFFF_FFFC;
    gen_stop        = 1'b0;
    err_popped      = 1'b0;
    post_err_grants = 0;
    topup();
    $display("branch to %h", a);
  endtask

  task automatic do_reset();
    int k;
    rst_i         = 1'b1;
    req_i         = 1'b0;
    branch_i      = 1'b0;
    fetch_ready_i = 1'b1;
    stray         = 1'b1;
    err_popped    = 1'b0;
    gen_stop      = 1'b1;
    exp_q.delete();
    $display("reset asserted with %0d requests outstanding", bus_q.size());
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    k = 0;
    while (bus_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("stray_drain", 32'(bus_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    stray = 1'b0;
    req_i = 1'b1;
    do_branch({$urandom_range(0, 255), 8'h00} << 4);
  endtask

  // Stimulus
  initial begin
    rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = '0;
    fetch_ready_i = 1'b0; stray = 1'b1; gen_stop = 1'b1; gen_addr = '0;
    err_popped = 1'b0; post_err_grants = 0; pops = 0; vectors = 0; errors = 0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk);
    #1;
    stray = 1'b0; req_i = 1'b1; fetch_ready_i = 1'b1;
    do_branch(32'h0000_0100);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      branch_i = 1'b0;
      if (c == 2000) do_reset();
      req_i         = ($urandom_range(0, 19) != 0);
      fetch_ready_i = ($urandom_range(0, 9) < 7);
      if (c < 300) fetch_ready_i = (c % 40) >= 20;
      if ($urandom_range(0, 24) == 0) do_branch($urandom);
      topup();
    end
    repeat (2) @(negedge clk);
    check("liveness", 32'(pops > 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Bus model: random grants, in-order responses at least one cycle after grant
  initial begin : bus_model
    logic        prev_held;
    logic [31:0] prev_addr;
    logic [31:0] a;
    prev_held = 1'b0;
    prev_addr = '0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      instr_gnt_i = ($urandom_range(0, 9) < 6);
      if (!rst_i && bus_q.size() != 0 && $urandom_range(0, 9) < 6) begin
        a              = bus_q[0];
        instr_rvalid_i = 1'b1;
        instr_err_i    = mem_err(a);
        instr_rdata_i  = instr_err_i ? $urandom : mem_word(a);
      end else begin
        instr_rvalid_i = 1'b0;
        instr_err_i    = 1'b0;
        instr_rdata_i  = $urandom;
      end
      @(negedge clk);
      if (!rst_i) begin
        if (!stray) begin
          check("busy", 32'(busy_o), 32'(instr_req_o | (bus_q.size() != 0)));
          check("max_outstanding", 32'(bus_q.size() <= MAX_OUT), 32'd1);
        end
        if (prev_held) begin
          check("req_hold", 32'(instr_req_o), 32'd1);
          check("addr_hold", instr_addr_o, prev_addr);
        end
        if (instr_rvalid_i) void'(bus_q.pop_front());
        if (instr_req_o && instr_gnt_i) begin
          check("addr_align", 32'(instr_addr_o[1:0]), 32'd0);
          bus_q.push_back(instr_addr_o);
          if (err_popped) begin
            post_err_grants++;
            check("stop_after_err", 32'(post_err_grants <= 1), 32'd1);
          end
        end
        prev_held = instr_req_o & ~instr_gnt_i;
        prev_addr = instr_addr_o;
      end else begin
        prev_held = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    bit prev_branch;
    prev_branch = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        check("reset_ctrl", 32'({fetch_valid_o, fetch_err_o, fetch_err_plus2_o, instr_req_o, busy_o}), 32'd0);
        check("reset_data", fetch_rdata_o | fetch_addr_o | instr_addr_o, 32'd0);
        prev_branch = 1'b0;
      end else begin
        if (stray) check("stray_valid", 32'(fetch_valid_o), 32'd0);
        if (prev_branch) check("flush", 32'(fetch_valid_o), 32'd0);
        if (fetch_valid_o && fetch_ready_i && !branch_i) begin
          pops++;
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_word: got addr %h data %h err %b, required no word",
                     fetch_addr_o, fetch_rdata_o, fetch_err_o);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("pop addr %h data %h err %b", fetch_addr_o, fetch_rdata_o, fetch_err_o);
            check("fetch_addr", fetch_addr_o, e.addr);
            check("fetch_rdata", fetch_rdata_o, e.data);
            check("fetch_err", 32'(fetch_err_o), 32'(e.err));
            check("fetch_err_plus2", 32'(fetch_err_plus2_o), 32'd0);
            if (e.err) err_popped = 1'b1;
          end
        end
        prev_branch = branch_i;
      end
    end
  end

endmodule
